// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/load requesters, the register-file write port
// and the decode-stage scoreboard lookup.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rs_busy;
    logic              rt_busy;
    logic              idle;

    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, rs_addr, rt_addr,
        output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, rs_busy, rt_busy, idle
    );

    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, rs_addr, rt_addr,
        input  alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, rs_busy, rt_busy, idle
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two 1-entry writeback slots (ALU, load) arbitrated onto one registered
// register-file write port, with a pending-write scoreboard for decode stalls.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;

    localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    slot_e             alu_st_q, alu_st_d, mem_st_q, mem_st_d;
    logic [ADDR_W-1:0] alu_reg_q, alu_reg_d, mem_reg_q, mem_reg_d, waddr_q, waddr_d;
    logic [DATA_W-1:0] alu_data_q, alu_data_d, mem_data_q, mem_data_d, wdata_q, wdata_d;
    logic              we_q, we_d, age_q, age_d;
    logic [SW-1:0]     starve_q, starve_d;

    logic alu_full, mem_full, grant_alu, grant_mem;
    logic alu_xfer, mem_xfer, alu_load, mem_load;

    assign alu_full = (alu_st_q == SLOT_FULL);
    assign mem_full = (mem_st_q == SLOT_FULL);

    // Equal destinations drain oldest-first; age_q set means MEM is the older slot.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (alu_full && mem_full) begin
            if (alu_reg_q == mem_reg_q) grant_alu = !age_q;
            else                        grant_alu = (starve_q == STARVE_LIM);
            grant_mem = !grant_alu;
        end else begin
            grant_alu = alu_full;
            grant_mem = mem_full;
        end
    end

    assign bus.alu_ready = !reset && (!alu_full || grant_alu);
    assign bus.mem_ready = !reset && (!mem_full || grant_mem);

    assign alu_xfer = bus.alu_valid && bus.alu_ready;
    assign mem_xfer = bus.mem_valid && bus.mem_ready;
    assign alu_load = alu_xfer && (bus.alu_reg != '0);
    assign mem_load = mem_xfer && (bus.mem_reg != '0);

    always_comb begin
        alu_st_d   = alu_st_q;
        alu_reg_d  = alu_reg_q;
        alu_data_d = alu_data_q;
        mem_st_d   = mem_st_q;
        mem_reg_d  = mem_reg_q;
        mem_data_d = mem_data_q;
        we_d       = grant_alu || grant_mem;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        starve_d   = '0;

        if (alu_load) begin
            alu_st_d   = SLOT_FULL;
            alu_reg_d  = bus.alu_reg;
            alu_data_d = bus.alu_data;
        end else if (alu_xfer || grant_alu) begin
            alu_st_d = SLOT_EMPTY;
        end

        if (mem_load) begin
            mem_st_d   = SLOT_FULL;
            mem_reg_d  = bus.mem_reg;
            mem_data_d = bus.mem_data;
        end else if (mem_xfer || grant_mem) begin
            mem_st_d = SLOT_EMPTY;
        end

        if (grant_alu) begin
            waddr_d = alu_reg_q;
            wdata_d = alu_data_q;
        end else if (grant_mem) begin
            waddr_d = mem_reg_q;
            wdata_d = mem_data_q;
        end

        if (alu_full && !grant_alu)
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);

        // A same-edge load of both slots also leaves MEM as the older entry.
        age_d = alu_load && (mem_st_d == SLOT_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_st_q   <= SLOT_EMPTY;
            alu_reg_q  <= '0;
            alu_data_q <= '0;
            mem_st_q   <= SLOT_EMPTY;
            mem_reg_q  <= '0;
            mem_data_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            starve_q   <= '0;
            age_q      <= 1'b0;
        end else begin
            alu_st_q   <= alu_st_d;
            alu_reg_q  <= alu_reg_d;
            alu_data_q <= alu_data_d;
            mem_st_q   <= mem_st_d;
            mem_reg_q  <= mem_reg_d;
            mem_data_q <= mem_data_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            starve_q   <= starve_d;
            age_q      <= age_d;
        end
    end

    assign bus.rf_we    = we_q;
    assign bus.rf_waddr = waddr_q;
    assign bus.rf_wdata = wdata_q;

    assign bus.rs_busy = (bus.rs_addr != '0) &&
                         ((alu_full && alu_reg_q == bus.rs_addr) ||
                          (mem_full && mem_reg_q == bus.rs_addr) ||
                          (we_q && waddr_q == bus.rs_addr));
    assign bus.rt_busy = (bus.rt_addr != '0) &&
                         ((alu_full && alu_reg_q == bus.rt_addr) ||
                          (mem_full && mem_reg_q == bus.rt_addr) ||
                          (we_q && waddr_q == bus.rt_addr));

    assign bus.idle = !alu_full && !mem_full && !we_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, $0 discard,
// priority/starvation, same-destination ordering and mid-operation reset.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                         input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md);
        bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        bus.rs_addr = '0; bus.rt_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", bus.rf_we); end
        n_checks++; if (bus.rf_waddr !== 5'd0) begin n_fail++; $display("FAIL rst_waddr got %0d exp 0", bus.rf_waddr); end
        n_checks++; if (bus.rf_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wdata got %h exp 0", bus.rf_wdata); end
        n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got %b exp 1", bus.idle); end
        n_checks++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_alu_ready got %b exp 0", bus.alu_ready); end
        n_checks++; if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ready got %b exp 0", bus.mem_ready); end
        reset = 1'b0;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_alu_ready got %b exp 1", bus.alu_ready); end
        n_checks++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_mem_ready got %b exp 1", bus.mem_ready); end
    endtask

    task automatic test_alu_single;
        bus.rs_addr = 5'd8;
        drive(1, 8, 32'hAA, 0, 0, 0);
        #1;
        n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b exp 1", bus.alu_ready); end
        n_checks++; if (bus.rs_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_pre got %b exp 0", bus.rs_busy); end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL single_e0_we got %b exp 0", bus.rf_we); end
        n_checks++; if (bus.rs_busy !== 1'b1) begin n_fail++; $display("FAIL single_e0_busy got %b exp 1", bus.rs_busy); end
        n_checks++; if (bus.idle !== 1'b0) begin n_fail++; $display("FAIL single_e0_idle got %b exp 0", bus.idle); end
        @(posedge clk); #1;
        n_checks++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL single_e1_we got %b exp 1", bus.rf_we); end
        n_checks++; if (bus.rf_waddr !== 5'd8) begin n_fail++; $display("FAIL single_e1_waddr got %0d exp 8", bus.rf_waddr); end
        n_checks++; if (bus.rf_wdata !== 32'hAA) begin n_fail++; $display("FAIL single_e1_wdata got %h exp 000000aa", bus.rf_wdata); end
        n_checks++; if (bus.rs_busy !== 1'b1) begin n_fail++; $display("FAIL single_e1_busy got %b exp 1", bus.rs_busy); end
        @(posedge clk); #1;
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL single_e2_we got %b exp 0", bus.rf_we); end
        n_checks++; if (bus.rs_busy !== 1'b0) begin n_fail++; $display("FAIL single_e2_busy got %b exp 0", bus.rs_busy); end
        n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL single_e2_idle got %b exp 1", bus.idle); end
    endtask

    task automatic test_reg0;
        bus.rs_addr = '0; bus.rt_addr = '0;
        drive(0, 0, 0, 1, 0, 32'hDEAD);
        #1;
        n_checks++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL reg0_ready got %b exp 1", bus.mem_ready); end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reg0_e0_we got %b exp 0", bus.rf_we); end
        n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL reg0_e0_idle got %b exp 1", bus.idle); end
        n_checks++; if (bus.rs_busy !== 1'b0) begin n_fail++; $display("FAIL reg0_rs_busy got %b exp 0", bus.rs_busy); end
        n_checks++; if (bus.rt_busy !== 1'b0) begin n_fail++; $display("FAIL reg0_rt_busy got %b exp 0", bus.rt_busy); end
        @(posedge clk); #1;
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reg0_e1_we got %b exp 0", bus.rf_we); end
    endtask

    task automatic test_priority;
        logic [AW-1:0] exp_addr [8] = '{5'd10, 5'd10, 5'd10, 5'd9, 5'd10, 5'd10, 5'd10, 5'd9};
        logic [DW-1:0] exp_data [8] = '{32'h1000, 32'h1001, 32'h1002, 32'h2000,
                                        32'h1003, 32'h1004, 32'h1005, 32'h2001};
        logic exp_ar [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic exp_mr [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int   alu_cnt = 0;
        int   mem_cnt = 0;
        logic ar, mr;
        drive(1, 9, 32'h2000, 1, 10, 32'h1000);
        for (int k = 0; k < 9; k++) begin
            #1;
            ar = bus.alu_ready;
            mr = bus.mem_ready;
            n_checks++; if (ar !== exp_ar[k]) begin n_fail++; $display("FAIL prio_alu_ready[%0d] got %b exp %b", k, ar, exp_ar[k]); end
            n_checks++; if (mr !== exp_mr[k]) begin n_fail++; $display("FAIL prio_mem_ready[%0d] got %b exp %b", k, mr, exp_mr[k]); end
            @(posedge clk); #1;
            if (ar === 1'b1) alu_cnt++;
            if (mr === 1'b1) mem_cnt++;
            drive(1, 9, 32'h2000 + DW'(alu_cnt), 1, 10, 32'h1000 + DW'(mem_cnt));
            if (k >= 1) begin
                n_checks++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL prio_we[%0d] got %b exp 1", k, bus.rf_we); end
                n_checks++; if (bus.rf_waddr !== exp_addr[k-1]) begin n_fail++; $display("FAIL prio_waddr[%0d] got %0d exp %0d", k, bus.rf_waddr, exp_addr[k-1]); end
                n_checks++; if (bus.rf_wdata !== exp_data[k-1]) begin n_fail++; $display("FAIL prio_wdata[%0d] got %h exp %h", k, bus.rf_wdata, exp_data[k-1]); end
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        n_checks++; if (bus.rf_waddr !== 5'd10 || bus.rf_wdata !== 32'h1006 || bus.rf_we !== 1'b1)
            begin n_fail++; $display("FAIL prio_drain_mem got we=%b %0d/%h exp 1 10/00001006", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        @(posedge clk); #1;
        n_checks++; if (bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'h2002 || bus.rf_we !== 1'b1)
            begin n_fail++; $display("FAIL prio_drain_alu got we=%b %0d/%h exp 1 9/00002002", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        @(posedge clk); #1;
        n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL prio_idle got %b exp 1", bus.idle); end
    endtask

    task automatic test_same_dest;
        // Part A: both slots loaded at the same edge for $5.
        logic          sav [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [AW-1:0] sar [5] = '{5'd12, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [DW-1:0] sad [5] = '{32'h0C, 32'h0, 32'h0, 32'h0, 32'h0};
        logic          smv [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [AW-1:0] smr [5] = '{5'd2, 5'd12, 5'd0, 5'd0, 5'd0};
        logic [DW-1:0] smd [5] = '{32'h02, 32'hC2, 32'h0, 32'h0, 32'h0};
        logic          ewe [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [AW-1:0] ewa [5] = '{5'd0, 5'd2, 5'd12, 5'd12, 5'd0};
        logic [DW-1:0] ewd [5] = '{32'h0, 32'h02, 32'h0C, 32'hC2, 32'h0};
        bus.rs_addr = 5'd5;
        drive(1, 5, 32'h11, 1, 5, 32'h22);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.rs_busy !== 1'b1) begin n_fail++; $display("FAIL same_e0_busy got %b exp 1", bus.rs_busy); end
        @(posedge clk); #1;
        n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'h22)
            begin n_fail++; $display("FAIL same_first got we=%b %0d/%h exp 1 5/00000022", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        @(posedge clk); #1;
        n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'h11)
            begin n_fail++; $display("FAIL same_second got we=%b %0d/%h exp 1 5/00000011", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        n_checks++; if (bus.rs_busy !== 1'b1) begin n_fail++; $display("FAIL same_e2_busy got %b exp 1", bus.rs_busy); end
        @(posedge clk); #1;
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL same_e3_we got %b exp 0", bus.rf_we); end
        n_checks++; if (bus.rs_busy !== 1'b0) begin n_fail++; $display("FAIL same_e3_busy got %b exp 0", bus.rs_busy); end
        // Part B: MEM loads $12 while an older ALU $12 waits; ALU must drain first.
        for (int i = 0; i < 5; i++) begin
            drive(sav[i], sar[i], sad[i], smv[i], smr[i], smd[i]);
            #1;
            if (sav[i]) begin n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL older_alu_ready[%0d] got %b exp 1", i, bus.alu_ready); end end
            if (smv[i]) begin n_checks++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL older_mem_ready[%0d] got %b exp 1", i, bus.mem_ready); end end
            @(posedge clk); #1;
            n_checks++; if (bus.rf_we !== ewe[i]) begin n_fail++; $display("FAIL older_we[%0d] got %b exp %b", i, bus.rf_we, ewe[i]); end
            if (ewe[i]) begin
                n_checks++; if (bus.rf_waddr !== ewa[i] || bus.rf_wdata !== ewd[i])
                    begin n_fail++; $display("FAIL older_write[%0d] got %0d/%h exp %0d/%h", i, bus.rf_waddr, bus.rf_wdata, ewa[i], ewd[i]); end
            end
        end
    endtask

    task automatic test_age_blocked;
        logic          sav [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [AW-1:0] sar [8] = '{5'd1, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0};
        logic [DW-1:0] sad [8] = '{32'h01, 32'h0, 32'h0, 32'h0, 32'h55, 32'h0, 32'h0, 32'h0};
        logic          smv [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [AW-1:0] smr [8] = '{5'd2, 5'd3, 5'd6, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [DW-1:0] smd [8] = '{32'h02, 32'h03, 32'h06, 32'h77, 32'h0, 32'h0, 32'h0, 32'h0};
        logic          ewe [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [AW-1:0] ewa [8] = '{5'd0, 5'd2, 5'd3, 5'd6, 5'd1, 5'd7, 5'd7, 5'd0};
        logic [DW-1:0] ewd [8] = '{32'h0, 32'h02, 32'h03, 32'h06, 32'h01, 32'h77, 32'h55, 32'h0};
        logic          ers [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bus.rs_addr = 5'd7; bus.rt_addr = 5'd1;
        for (int i = 0; i < 8; i++) begin
            drive(sav[i], sar[i], sad[i], smv[i], smr[i], smd[i]);
            #1;
            if (sav[i]) begin n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL age_alu_ready[%0d] got %b exp 1", i, bus.alu_ready); end end
            if (smv[i]) begin n_checks++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL age_mem_ready[%0d] got %b exp 1", i, bus.mem_ready); end end
            @(posedge clk); #1;
            n_checks++; if (bus.rf_we !== ewe[i]) begin n_fail++; $display("FAIL age_we[%0d] got %b exp %b", i, bus.rf_we, ewe[i]); end
            if (ewe[i]) begin
                n_checks++; if (bus.rf_waddr !== ewa[i] || bus.rf_wdata !== ewd[i])
                    begin n_fail++; $display("FAIL age_write[%0d] got %0d/%h exp %0d/%h", i, bus.rf_waddr, bus.rf_wdata, ewa[i], ewd[i]); end
            end
            n_checks++; if (bus.rs_busy !== ers[i]) begin n_fail++; $display("FAIL age_rs_busy[%0d] got %b exp %b", i, bus.rs_busy, ers[i]); end
        end
        n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL age_idle got %b exp 1", bus.idle); end
    endtask

    task automatic test_reset_mid;
        bus.rs_addr = 5'd3; bus.rt_addr = 5'd4;
        drive(1, 4, 32'h44, 1, 3, 32'h33);
        @(posedge clk); #1;
        n_checks++; if (bus.rs_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_rs_busy got %b exp 1", bus.rs_busy); end
        n_checks++; if (bus.rt_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_rt_busy got %b exp 1", bus.rt_busy); end
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        n_checks++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0)
            begin n_fail++; $display("FAIL rmid_ready_in_reset got %b%b exp 00", bus.alu_ready, bus.mem_ready); end
        @(posedge clk); #1;
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we_at_reset got %b exp 0", bus.rf_we); end
        n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL rmid_idle got %b exp 1", bus.idle); end
        n_checks++; if (bus.rs_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_cleared got %b exp 0", bus.rs_busy); end
        reset = 1'b0;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1)
            begin n_fail++; $display("FAIL rmid_ready_after got %b%b exp 11", bus.alu_ready, bus.mem_ready); end
        @(posedge clk); #1;
        n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we_after got %b exp 0", bus.rf_we); end
        n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL rmid_idle_after got %b exp 1", bus.idle); end
    endtask

    initial begin
        test_reset;
        test_alu_single;
        test_reg0;
        test_priority;
        test_same_dest;
        test_age_blocked;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
